// File: rtl/seven_seg_scroller.sv
// Scrolls a buffered message of 3-bit symbol codes right-to-left across N_DIGITS seven-segment digits.
// Build macro SEVEN_SEG_SCROLLER_LOOP_EN: when defined, passes repeat until stop_i instead of returning to IDLE.
module seven_seg_scroller #(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int MSG_LEN     = 8,
    parameter int N_DIGITS    = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_valid_i,
    input  logic [2:0]              wr_code_i,
    output logic                    wr_ready_o,
    input  logic                    clr_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [3*N_DIGITS-1:0]   code_o,
    output logic [N_DIGITS-1:0]     blank_o
);
    localparam int LW = $clog2(MSG_LEN + N_DIGITS + 1);
    localparam int IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LW-1:0] MSG_LEN_L  = LW'(MSG_LEN);
    localparam logic [LW-1:0] LAST_OFS_L = LW'(N_DIGITS - 1);
    localparam logic [LW-1:0] ONE_L      = LW'(1);
    localparam logic [CW-1:0] CNT_LAST_L = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE_L  = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nx;
    logic [LW-1:0]              r_len;
    logic [LW-1:0]              w_len_nx;
    logic [LW-1:0]              w_len_base;
    logic [2:0]                 r_buf [MSG_LEN];
    logic [2:0]                 w_buf_nx [MSG_LEN];
    logic [LW-1:0]              r_step;
    logic [LW-1:0]              w_step_nx;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              w_cnt_nx;
    logic [3*N_DIGITS-1:0]      r_code;
    logic [3*N_DIGITS-1:0]      w_code_nx;
    logic [N_DIGITS-1:0]        r_blank;
    logic [N_DIGITS-1:0]        w_blank_nx;
    logic                       r_busy;
    logic                       r_done;
    logic                       w_done_nx;
    logic                       w_wr_acc;
    logic [LW-1:0]              w_last_step;
    logic [LW-1:0]              w_last_nx;
    logic [LW-1:0]              w_pos;

    assign wr_ready_o  = (r_state == ST_IDLE) && (r_len < MSG_LEN_L);
    assign w_wr_acc    = wr_valid_i && wr_ready_o;
    assign w_last_step = r_len + LAST_OFS_L;
    assign w_last_nx   = w_len_nx + LAST_OFS_L;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign code_o      = r_code;
    assign blank_o     = r_blank;

    // Next-state logic for the FSM, symbol buffer, step index and step counter
    always_comb begin
        w_state_nx = r_state;
        w_len_nx   = r_len;
        w_len_base = '0;
        w_buf_nx   = r_buf;
        w_step_nx  = r_step;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_i) begin
                    w_len_base = '0;
                end else begin
                    w_len_base = r_len;
                end
                // A same-cycle clear makes the write land at index 0
                if (w_wr_acc) begin
                    w_buf_nx[w_len_base[IW-1:0]] = wr_code_i;
                    w_len_nx = w_len_base + ONE_L;
                end else begin
                    w_len_nx = w_len_base;
                end
                if (start_i && !stop_i && (w_len_nx != '0)) begin
                    w_state_nx = ST_SCROLL;
                end else begin
                    w_state_nx = ST_IDLE;
                end
                w_step_nx = '0;
                w_cnt_nx  = '0;
            end
            ST_SCROLL: begin
                if (stop_i) begin
                    w_state_nx = ST_IDLE;
                    w_step_nx  = '0;
                    w_cnt_nx   = '0;
                end else if (r_cnt == CNT_LAST_L) begin
                    w_cnt_nx = '0;
                    if (r_step == w_last_step) begin
                        w_step_nx = '0;
`ifdef SEVEN_SEG_SCROLLER_LOOP_EN
                        w_state_nx = ST_SCROLL;
`else
                        w_state_nx = ST_IDLE;
`endif
                    end else begin
                        w_step_nx = r_step + ONE_L;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE_L;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_step_nx  = '0;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Display window computed from next-state values so registered outputs line up with the step
    always_comb begin
        w_code_nx  = '0;
        w_blank_nx = '1;
        w_pos      = '0;
        w_done_nx  = 1'b0;
        if (w_state_nx == ST_SCROLL) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                w_pos = w_step_nx - LW'(k);
                if ((w_step_nx >= LW'(k)) && (w_pos < w_len_nx)) begin
                    w_code_nx[3*k +: 3] = w_buf_nx[w_pos[IW-1:0]];
                    w_blank_nx[k]       = 1'b0;
                end else begin
                    w_code_nx[3*k +: 3] = 3'b000;
                    w_blank_nx[k]       = 1'b1;
                end
            end
            w_done_nx = (w_step_nx == w_last_nx) && (w_cnt_nx == CNT_LAST_L);
        end else begin
            w_code_nx  = '0;
            w_blank_nx = '1;
            w_done_nx  = 1'b0;
        end
    end

    // State, buffer and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_buf   <= '{default: 3'b000};
            r_step  <= '0;
            r_cnt   <= '0;
            r_code  <= '0;
            r_blank <= '1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_len   <= w_len_nx;
            r_buf   <= w_buf_nx;
            r_step  <= w_step_nx;
            r_cnt   <= w_cnt_nx;
            r_code  <= w_code_nx;
            r_blank <= w_blank_nx;
            r_busy  <= (w_state_nx == ST_SCROLL);
            r_done  <= w_done_nx;
        end
    end
endmodule
